// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register-file write port, with a bounded burst lock
// and a registered write stage that drives wr_en/write_addr/write_data.
module rf_write_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_lock,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [15:0]       busy_mask,
  output logic              locked
);

  localparam int unsigned CntW = $clog2(LOCK_MAX);

  typedef enum logic {StArb, StLocked} state_e;

  state_e            r_state, w_state_next;
  logic              r_last_grant, w_last_grant_next;
  logic              r_owner, w_owner_next;
  logic [CntW-1:0]   r_lock_cnt, w_lock_cnt_next;
  logic [1:0]        w_ready;
  logic              w_accept;
  logic              w_winner;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_write_addr;
  logic [DATA_W-1:0] r_write_data;

  // Ready is forced low during reset so nothing is accepted before the edge-free reset ends.
  always_comb begin
    w_ready = 2'b00;
    if (!rst) begin
      unique case (r_state)
        StArb: begin
          if (req_valid == 2'b11) w_ready[~r_last_grant] = 1'b1;
          else                    w_ready = req_valid;
        end
        StLocked: w_ready[r_owner] = req_valid[r_owner];
      endcase
    end
  end

  assign req_ready = w_ready;
  assign w_accept  = |(req_valid & w_ready);
  assign w_winner  = w_ready[1];

  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_owner_next      = r_owner;
    w_lock_cnt_next   = r_lock_cnt;
    unique case (r_state)
      StArb: begin
        if (w_accept) begin
          w_last_grant_next = w_winner;
          if (req_lock[w_winner]) begin
            w_state_next    = StLocked;
            w_owner_next    = w_winner;
            w_lock_cnt_next = '0;
          end
        end
      end
      StLocked: begin
        w_lock_cnt_next = r_lock_cnt + CntW'(1);
        // Leaving the lock hands the next tie to the other requester.
        if ((w_accept && !req_lock[r_owner]) || (r_lock_cnt == CntW'(LOCK_MAX - 1))) begin
          w_state_next      = StArb;
          w_last_grant_next = r_owner;
          w_lock_cnt_next   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StArb;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_lock_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
      r_owner      <= w_owner_next;
      r_lock_cnt   <= w_lock_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en      <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_write_addr <= w_winner ? req_addr1 : req_addr0;
        r_write_data <= w_winner ? req_data1 : req_data0;
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign write_addr = r_write_addr;
  assign write_data = r_write_data;
  assign busy_mask  = r_wr_en ? (16'(1) << r_write_addr) : 16'h0000;
  assign locked     = (r_state == StLocked);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a cycle-level policy model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_rf_write_arbiter;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned LOCK_MAX = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_lock;
  logic [ADDR_W-1:0] req_addr0, req_addr1;
  logic [DATA_W-1:0] req_data0, req_data1;
  logic [1:0]        req_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [15:0]       busy_mask;
  logic              locked;

  rf_write_arbiter #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_lock   (req_lock),
    .req_addr0  (req_addr0),
    .req_data0  (req_data0),
    .req_addr1  (req_addr1),
    .req_data1  (req_data1),
    .req_ready  (req_ready),
    .wr_en      (wr_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .busy_mask  (busy_mask),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Policy model: who owns the port (-1 = nobody), cycles spent owned, who won last.
  int          m_owner;
  int          m_held;
  int          m_last;
  logic        m_wen;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_rdy;

  logic [1:0]  cap_rdy;
  logic        cap_locked;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] model_ready();
    logic [1:0] r;
    if (m_owner >= 0)            r = req_valid[m_owner] ? 2'(1 << m_owner) : 2'b00;
    else if (req_valid == 2'b11) r = (m_last == 0) ? 2'b10 : 2'b01;
    else                         r = req_valid;
    return r;
  endfunction

  // One clock: compare everything against the model, take the edge, advance the model.
  task automatic cycle();
    int win;
    logic acc;
    #1;
    m_rdy = model_ready();
    cap_rdy = req_ready;
    cap_locked = locked;
    chk("ready", req_ready, m_rdy);
    chk("wr_en", wr_en, m_wen);
    chk("write_addr", write_addr, m_addr);
    chk("write_data", write_data, m_data);
    chk("busy_mask", busy_mask, m_wen ? 16'(1 << m_addr) : 16'h0);
    chk("locked", locked, m_owner >= 0);
    @(posedge clk);
    acc = |(req_valid & m_rdy);
    win = m_rdy[1] ? 1 : 0;
    m_wen = acc;
    if (acc) begin
      m_addr = win ? req_addr1 : req_addr0;
      m_data = win ? req_data1 : req_data0;
    end
    if (m_owner < 0) begin
      if (acc) begin
        m_last = win;
        if (req_lock[win]) begin
          m_owner = win;
          m_held  = 0;
        end
      end
    end else begin
      m_held++;
      if ((acc && !req_lock[m_owner]) || m_held == LOCK_MAX) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_ready", req_ready, 2'b00);
    m_owner = -1; m_held = 0; m_last = 1;
    m_wen = 1'b0; m_addr = '0; m_data = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lock_cycles;
    int n;
    rst = 1'b1;
    req_valid = 2'b00; req_lock = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_data0 = '0; req_data1 = '0;
    do_reset();

    // Single request.
    req_valid = 2'b01; req_addr0 = 4'd3; req_data0 = 32'h11111111;
    cycle();
    chk("t1_rdy", cap_rdy, 2'b01);
    chk("t1_wen", wr_en, 1'b1);
    chk("t1_addr", write_addr, 4'd3);
    chk("t1_data", write_data, 32'h11111111);
    chk("t1_mask", busy_mask, 16'h0008);
    req_valid = 2'b00;
    cycle();

    // Tie after reset alternates 0,1,0,1 with no write bubbles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b11;
      req_addr0 = 4'd1; req_data0 = 32'hA0000000 + 32'(i);
      req_addr1 = 4'd2; req_data1 = 32'hB0000000 + 32'(i);
      cycle();
      chk("t2_grant", cap_rdy, (i % 2 == 1) ? 2'b10 : 2'b01);
      chk("t2_wen", wr_en, 1'b1);
    end
    chk("t2_last_data", write_data, 32'hB0000003);
    req_valid = 2'b00;
    cycle();

    // Give req 0 the last grant so req 1 wins the tie that starts its burst.
    req_valid = 2'b01; req_addr0 = 4'd7; req_data0 = 32'h77777777;
    cycle();
    for (int j = 0; j < 3; j++) begin
      req_valid = 2'b11;
      req_lock  = (j < 2) ? 2'b10 : 2'b00;
      req_addr0 = 4'd9; req_data0 = 32'h99999999;
      req_addr1 = 4'(4 + j); req_data1 = 32'hC0000000 + 32'(j);
      cycle();
      chk("t3_rdy", cap_rdy, 2'b10);
      chk("t3_locked", cap_locked, j > 0);
      chk("t3_addr", write_addr, 4'(4 + j));
    end
    req_lock = 2'b00;
    cycle();
    chk("t3_req0_after", cap_rdy, 2'b01);
    chk("t3_req0_addr", write_addr, 4'd9);
    req_valid = 2'b00;
    cycle();

    // Lock timeout: req 1 locks then vanishes while req 0 waits.
    req_valid = 2'b10; req_lock = 2'b10; req_addr1 = 4'd10; req_data1 = 32'hDDDDDDDD;
    cycle();
    req_valid = 2'b01; req_lock = 2'b00; req_addr0 = 4'd11; req_data0 = 32'hEEEEEEEE;
    lock_cycles = 0;
    n = 0;
    do begin
      cycle();
      if (cap_locked) lock_cycles++;
      n++;
    end while (cap_rdy != 2'b01 && n < 20);
    chk("t4_lock_cycles", lock_cycles, LOCK_MAX);
    chk("t4_req0_accepted", cap_rdy, 2'b01);
    chk("t4_write", write_data, 32'hEEEEEEEE);
    req_valid = 2'b00;
    cycle();

    // Reset in the middle of a locked burst with a write in flight.
    req_valid = 2'b10; req_lock = 2'b10; req_addr1 = 4'd12; req_data1 = 32'h12121212;
    cycle();
    chk("t5_pre_locked", locked, 1'b1);
    chk("t5_pre_wen", wr_en, 1'b1);
    req_valid = 2'b11;
    do_reset();
    req_lock = 2'b00;
    cycle();
    chk("t5_tie_after_reset", cap_rdy, 2'b01);
    req_valid = 2'b00;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
